wb_ram_responder: RTL and testbench
===================================

// Module: wb_ram_responder
// PURPOSE
//  Wishbone B4 pipelined-mode responder that fronts a word-addressed on-chip data RAM.
//  It is the target end of the data-memory bus driven by the ME stage's DMEM initiator.
//  It accepts one request at a time and inserts programmable wait states.
//  It applies byte-lane writes and returns read data with oAck.
//  Out-of-range addresses are terminated with oErr.
// PARAMETERS
//  DEPTH        1024  RAM size in 32-bit words; legal word index 0..DEPTH-1
//  ADDR_W       32    byte-address width of iAddr
//  WAIT_STATES  0     extra cycles between accept and ack (0..15)
// PORTS
//  iClk     in   1       clock, rising edge
//  nRst     in   1       reset, asynchronous, active-low
//  iCyc     in   1       bus cycle active
//  iStb     in   1       request strobe
//  iWe      in   1       1=write, 0=read
//  iAddr    in   ADDR_W  byte address; word index = iAddr[ADDR_W-1:2]; iAddr[1:0] ignored
//  iDat     in   32      write data
//  iSel     in   4       byte-lane enables; bit n = iDat[8n+7:8n]
//  oDat     out  32      read data, valid only while oAck=1
//  oAck     out  1       normal termination, one-cycle pulse
//  oErr     out  1       error termination (address out of range), one-cycle pulse
//  oStall   out  1       1 = request not accepted this cycle
// BEHAVIOUR
//  Reset
//   - Async on nRst low: state=IDLE, wait counter=0.
//   - oAck=0, oErr=0, oStall=0, oDat=0, captured request registers=0.
//   - RAM contents are not cleared.
//  FSM: IDLE, WAIT, RESP
//   - IDLE: oStall=0. Accept at a rising edge where iCyc&iStb=1.
//     On accept, capture we/addr/dat/sel.
//     Word index >= DEPTH -> RESP with err flag set; WAIT_STATES is skipped.
//     Otherwise -> WAIT with cnt=WAIT_STATES; when WAIT_STATES=0, go directly to RESP.
//   - WAIT: oStall=1. cnt decrements each edge; cnt==0 at an edge -> RESP.
//   - RESP: oStall=1. Exactly one of oAck/oErr=1 for this single cycle. Next edge -> IDLE.
//  Data path
//   - Write: RAM lanes selected by captured sel are updated at the edge entering RESP.
//     Other lanes are unchanged.
//   - Read: RAM word is registered into oDat at the edge entering RESP.
//   - oDat=0 whenever oAck=0.
//  Latency
//   - Accept edge E -> oAck/oErr high in the cycle after edge E+WAIT_STATES.
//   - Minimum 2 cycles per transaction: no back-to-back accept while in RESP.
//  Boundary conditions
//   - iCyc drops in WAIT: abort to IDLE at the next edge. No RAM write, no ack/err.
//   - iCyc drops in RESP: the pulse still completes; the initiator ignores it.
//   - iStb without iCyc: ignored.
//   - iSel=4'b0000 write: acked normally, RAM unchanged.
//   - Error responses never write RAM.
//   - Error reads return oDat=0.
//   - Reset mid-transaction: immediate IDLE.
//     No ack/err is ever produced for the aborted request.
//     A write whose RESP-entry edge has not occurred is not committed.
//   - oAck and oErr are never both 1.
// TESTING
//  1 Write/read, WAIT_STATES=0:
//    write 0xDEADBEEF to 0x10 (sel=F), then read 0x10
//    -> oAck 1 cycle after each accept; oDat=0xDEADBEEF.
//  2 Byte lanes:
//    preload 0x11223344 at 0x20; write 0xAABBCCDD with sel=4'b0101; read
//    -> 0x11BB33DD.
//  3 Wait states, WAIT_STATES=3:
//    read accepted at edge E -> oStall=1 for 4 cycles; oAck high in the cycle after E+3; no earlier ack.
//  4 Range error, DEPTH=1024:
//    write 0x5A5A5A5A to 0x1000 -> oErr=1, oAck=0, oDat=0;
//    read 0x0 is unaffected; the RAM at every index is unchanged.
//  5 Abort, WAIT_STATES=3:
//    write 0xCAFEF00D to 0x40; drop iCyc during WAIT
//    -> no oAck/oErr; a later read of 0x40 returns the old value.
//  6 Reset mid-op:
//    assert nRst=0 asynchronously in WAIT
//    -> all outputs 0 immediately, no ack after release, next request serviced normally.

Source files
------------

// File: rtl/wb_ram_responder.sv
// wb_ram_responder: Wishbone B4 pipelined responder in front of a word-addressed
// on-chip data RAM. One request at a time, programmable wait states, byte-lane
// writes, and error termination for out-of-range word indices.
//
// Ports:
//   iClk    in   clock, rising edge
//   nRst    in   asynchronous active-low reset
//   iCyc    in   bus cycle active
//   iStb    in   request strobe
//   iWe     in   1 = write, 0 = read
//   iAddr   in   byte address; word index = iAddr[ADDR_W-1:2]
//   iDat    in   write data
//   iSel    in   byte-lane enables (bit n -> iDat[8n+7:8n])
//   oDat    out  read data, zero whenever oAck is low
//   oAck    out  normal termination pulse
//   oErr    out  error termination pulse (word index >= DEPTH)
//   oStall  out  request not accepted this cycle
module wb_ram_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              iClk,
    input  logic              nRst,
    input  logic              iCyc,
    input  logic              iStb,
    input  logic              iWe,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [31:0]       iDat,
    input  logic [3:0]        iSel,
    output logic [31:0]       oDat,
    output logic              oAck,
    output logic              oErr,
    output logic              oStall
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdat_q, wdat_d;
    logic [3:0]         sel_q, sel_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               stall_q, stall_d;
    logic [31:0]        rdat_q, rdat_d;

    // Effective request: live inputs on the accept edge, captured copy afterwards
    logic               req_we_c;
    logic [IDX_W-1:0]   req_idx_c;
    logic [31:0]        req_dat_c;
    logic [3:0]         req_sel_c;
    logic               go_resp_c;
    logic               ram_we_c;

    logic [31:0]        mem [DEPTH];

    // Byte offset bits do not take part in word addressing
    logic               unused_addr_lsb;
    assign unused_addr_lsb = ^iAddr[1:0];

    // State and captured-request registers
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            rdat_q  <= rdat_d;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdat_d    = '0;
        go_resp_c = 1'b0;
        req_we_c  = we_q;
        req_idx_c = idx_q;
        req_dat_c = wdat_q;
        req_sel_c = sel_q;

        case (state_q)
            S_IDLE: begin
                req_we_c  = iWe;
                req_idx_c = iAddr[ADDR_W-1:2];
                req_dat_c = iDat;
                req_sel_c = iSel;
                if (iCyc && iStb) begin
                    we_d   = iWe;
                    idx_d  = iAddr[ADDR_W-1:2];
                    wdat_d = iDat;
                    sel_d  = iSel;
                    if (req_idx_c >= IDX_W'(DEPTH)) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        state_d   = S_RESP;
                        go_resp_c = 1'b1;
                    end else begin
                        // Loaded one short so RESP is entered on edge E+WAIT_STATES
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!iCyc) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d   = S_RESP;
                    go_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ack_d    = go_resp_c;
        ram_we_c = go_resp_c && req_we_c;
        if (go_resp_c && !req_we_c) begin
            rdat_d = mem[req_idx_c[MEM_AW-1:0]];
        end
        stall_d = (state_d != S_IDLE);
    end

    // RAM array with per-lane write enables; contents survive reset
    always_ff @(posedge iClk) begin
        if (ram_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel_c[b]) begin
                    mem[req_idx_c[MEM_AW-1:0]][8*b +: 8] <= req_dat_c[8*b +: 8];
                end
            end
        end
    end

    assign oDat   = rdat_q;
    assign oAck   = ack_q;
    assign oErr   = err_q;
    assign oStall = stall_q;

endmodule

// File: tb/tb_wb_ram_responder.sv
// tb_wb_ram_responder: directed bench for wb_ram_responder. Two instances share
// the request bus: u_dut0 runs with no wait states, u_dut3 with three. use3
// routes iCyc and the observed outputs to one of them.
module tb_wb_ram_responder;

    logic        clk;
    logic        nrst;
    logic        cyc, stb, we;
    logic [31:0] addr, wdat;
    logic [3:0]  sel;
    logic        use3;

    logic [31:0] dat0, dat3;
    logic        ack0, ack3, err0, err3, stall0, stall3;

    logic [31:0] cur_dat;
    logic        cur_ack, cur_err, cur_stall;

    int n_checks;
    int n_fail;

    assign cur_dat   = use3 ? dat3   : dat0;
    assign cur_ack   = use3 ? ack3   : ack0;
    assign cur_err   = use3 ? err3   : err0;
    assign cur_stall = use3 ? stall3 : stall0;

    wb_ram_responder #(.DEPTH(1024), .ADDR_W(32), .WAIT_STATES(0)) u_dut0 (
        .iClk(clk), .nRst(nrst), .iCyc(cyc && !use3), .iStb(stb), .iWe(we),
        .iAddr(addr), .iDat(wdat), .iSel(sel),
        .oDat(dat0), .oAck(ack0), .oErr(err0), .oStall(stall0)
    );

    wb_ram_responder #(.DEPTH(1024), .ADDR_W(32), .WAIT_STATES(3)) u_dut3 (
        .iClk(clk), .nRst(nrst), .iCyc(cyc && use3), .iStb(stb), .iWe(we),
        .iAddr(addr), .iDat(wdat), .iSel(sel),
        .oDat(dat3), .oAck(ack3), .oErr(err3), .oStall(stall3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request, held for the accept edge; waits (bounded) for ack/err.
    // lat = edges after the accept edge before the pulse is visible.
    task automatic bus_txn(input logic t_we, input logic [31:0] t_addr,
                           input logic [31:0] t_dat, input logic [3:0] t_sel,
                           output logic [31:0] rdat, output logic ack, output logic err,
                           output int lat, output logic after);
        cyc = 1'b1; stb = 1'b1; we = t_we; addr = t_addr; wdat = t_dat; sel = t_sel;
        @(posedge clk); #1;
        stb = 1'b0;
        lat = 0;
        while (!(cur_ack || cur_err) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        ack  = cur_ack;
        err  = cur_err;
        rdat = cur_dat;
        cyc  = 1'b0;
        @(posedge clk); #1;
        after = cur_ack | cur_err;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int exp_lat);
        logic [31:0] r;
        logic        k, e, af;
        int          l;
        bus_txn(1'b1, a, d, s, r, k, e, l, af);
        check({tag, "_ack"}, 32'(k), 32'd1);
        check({tag, "_err"}, 32'(e), 32'd0);
        check({tag, "_lat"}, 32'(l), 32'(exp_lat));
        check({tag, "_pulse_end"}, 32'(af), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp,
                           input int exp_lat);
        logic [31:0] r;
        logic        k, e, af;
        int          l;
        bus_txn(1'b0, a, 32'h0, 4'h0, r, k, e, l, af);
        check({tag, "_ack"}, 32'(k), 32'd1);
        check({tag, "_err"}, 32'(e), 32'd0);
        check({tag, "_lat"}, 32'(l), 32'(exp_lat));
        check({tag, "_dat"}, r, exp);
        check({tag, "_pulse_end"}, 32'(af), 32'd0);
    endtask

    task automatic do_err(input string tag, input logic t_we, input logic [31:0] a,
                          input logic [31:0] d);
        logic [31:0] r;
        logic        k, e, af;
        int          l;
        bus_txn(t_we, a, d, 4'hF, r, k, e, l, af);
        check({tag, "_err"}, 32'(e), 32'd1);
        check({tag, "_ack"}, 32'(k), 32'd0);
        check({tag, "_dat"}, r, 32'h0);
        check({tag, "_lat"}, 32'(l), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nrst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdat = '0; sel = '0; use3 = 1'b0;

        // Reset state of both instances
        #12;
        check("rst_ack0",   32'(ack0),   32'd0);
        check("rst_err0",   32'(err0),   32'd0);
        check("rst_stall0", 32'(stall0), 32'd0);
        check("rst_dat0",   dat0,        32'h0);
        check("rst_stall3", 32'(stall3), 32'd0);
        check("rst_dat3",   dat3,        32'h0);
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;

        // Basic write/read, zero wait states
        do_write("t1_wr", 32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_read ("t1_rd", 32'h10, 32'hDEADBEEF, 0);

        // Byte lanes and the empty-select write
        do_write("t2_pre", 32'h20, 32'h11223344, 4'hF, 0);
        do_write("t2_wr",  32'h20, 32'hAABBCCDD, 4'b0101, 0);
        do_read ("t2_rd",  32'h20, 32'h11BB33DD, 0);
        do_write("t2_sel0", 32'h20, 32'hFFFFFFFF, 4'b0000, 0);
        do_read ("t2_rd0",  32'h20, 32'h11BB33DD, 0);

        // Range errors: word index 1024 would alias index 0 if decoded narrow
        do_write("t4_pre0", 32'h0, 32'h01020304, 4'hF, 0);
        do_err("t4_werr", 1'b1, 32'h1000, 32'h5A5A5A5A);
        do_err("t4_rerr", 1'b0, 32'h0000_2004, 32'h0);
        do_read("t4_rd0",  32'h0,  32'h01020304, 0);
        do_read("t4_rd10", 32'h10, 32'hDEADBEEF, 0);
        do_read("t4_rd20", 32'h20, 32'h11BB33DD, 0);

        // Three wait states: stall profile and ack placement
        use3 = 1'b1;
        do_write("t3_wr", 32'h40, 32'h12345678, 4'hF, 3);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h40; sel = 4'hF;
        @(posedge clk); #1;
        stb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_stall%0d", k), 32'(cur_stall), 32'd1);
            check($sformatf("t3_ack%0d", k),   32'(cur_ack),   32'(k == 3));
            if (k == 3) check("t3_dat", cur_dat, 32'h12345678);
            else        check($sformatf("t3_dat_idle%0d", k), cur_dat, 32'h0);
            if (k < 3) begin
                @(posedge clk); #1;
            end
        end
        cyc = 1'b0;
        @(posedge clk); #1;
        check("t3_stall_end", 32'(cur_stall), 32'd0);
        check("t3_ack_end",   32'(cur_ack),   32'd0);

        // Abort: iCyc dropped in WAIT
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h40; wdat = 32'hCAFEF00D; sel = 4'hF;
        @(posedge clk); #1;
        stb = 1'b0;
        check("t5_stall_wait", 32'(cur_stall), 32'd1);
        cyc = 1'b0;
        @(posedge clk); #1;
        check("t5_stall_idle", 32'(cur_stall), 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 5; k++) begin
                seen = seen | cur_ack | cur_err;
                @(posedge clk); #1;
            end
            check("t5_no_resp", 32'(seen), 32'd0);
        end
        do_read("t5_rd", 32'h40, 32'h12345678, 3);

        // Reset in WAIT: outputs clear at once, write never commits
        do_write("t6_pre", 32'h50, 32'h13579BDF, 4'hF, 3);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h50; wdat = 32'h77777777; sel = 4'hF;
        @(posedge clk); #1;
        stb = 1'b0;
        check("t6_stall_pre", 32'(cur_stall), 32'd1);
        #1 nrst = 1'b0;
        #1;
        check("t6_rst_stall", 32'(cur_stall), 32'd0);
        check("t6_rst_ack",   32'(cur_ack),   32'd0);
        check("t6_rst_err",   32'(cur_err),   32'd0);
        check("t6_rst_dat",   cur_dat,        32'h0);
        cyc = 1'b0;
        #2 nrst = 1'b1;
        @(posedge clk); #1;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                seen = seen | cur_ack | cur_err;
                @(posedge clk); #1;
            end
            check("t6_no_resp", 32'(seen), 32'd0);
        end
        do_read("t6_rd", 32'h50, 32'h13579BDF, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
